// File: rtl/fnd_scan_mux.sv
// fnd_scan_mux -- time-multiplexed scan driver for a DIGITS-wide 7-segment
// (FND) display.
//
// A prescaler holds each digit selected for DIV clocks. After the last digit
// the index wraps to 0. On that wrap the packed input values are copied into a
// snapshot register, so a frame never mixes old and new digits.
//
// Optional feature: define FND_LEADING_ZERO_BLANK_EN to blank leading zero
// digits. Digit 0 is never blanked.
//
// Ports:
//   i_clk         clock; all state changes on the rising edge
//   i_reset_n     asynchronous active-low reset
//   i_enable      1 = scan runs; 0 = scan frozen and display dark
//   i_values      packed digit values; digit k at [k*WIDTH +: WIDTH]
//   o_value       snapshot value of the selected digit
//   o_site_sel    index of the selected digit
//   o_digit_sel   active-low one-hot digit enable
//   o_frame_tick  one-cycle pulse after a new snapshot is taken
module fnd_scan_mux #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4,
  parameter int DIV    = 100000,
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic [DIGITS*WIDTH-1:0]   i_values,
  output logic [WIDTH-1:0]          o_value,
  output logic [SEL_W-1:0]          o_site_sel,
  output logic [DIGITS-1:0]         o_digit_sel,
  output logic                      o_frame_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [SEL_W-1:0]        idx;
  logic [DIGITS*WIDTH-1:0] snap;
  logic                    tick_q;
  logic                    step;
  logic                    wrap;
  logic                    blank;

  // When DIV is 1, CNT_MAX is 0. In that case every enabled cycle is a step.
  assign step = i_enable && (cnt == CNT_MAX);
  assign wrap = step && (idx == IDX_MAX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt    <= '0;
      idx    <= '0;
      snap   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (i_enable) cnt <= step ? '0 : cnt + 1'b1;
      if (step)     idx <= wrap ? '0 : idx + 1'b1;
      if (wrap)     snap <= i_values;
    end
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Bit k of nz is set when snapshot digit k is nonzero.
  // A digit slot is blank when idx is not 0 and no digit at idx or above is
  // nonzero.
  logic [DIGITS-1:0] nz;
  for (genvar k = 0; k < DIGITS; k++) begin : g_nz
    assign nz[k] = |snap[k*WIDTH +: WIDTH];
  end
  assign blank = (idx != '0) && ((nz >> idx) == '0);
`else
  assign blank = 1'b0;
`endif

  assign o_site_sel = idx;
  assign o_value    = snap[idx*WIDTH +: WIDTH];

  // Reset gates the enables directly, so the display goes dark without
  // waiting for a clock edge.
  always_comb begin
    o_digit_sel = '1;
    if (i_reset_n && i_enable && !blank) o_digit_sel[idx] = 1'b0;
  end

  // The pulse is masked while the scan is frozen, so it cannot fire while
  // i_enable is low.
  assign o_frame_tick = tick_q & i_enable;

endmodule

// File: tb/tb_fnd_scan_mux.sv
// Randomized check of fnd_scan_mux against a frame-level reference model.
// Two instances share the clock, enable and reset:
//   u4: DIGITS=4, WIDTH=4, DIV=3
//   u5: DIGITS=5, WIDTH=4, DIV=1
// The model counts enabled cycles since reset. From that count it derives
// the slot with plain division. A snapshot is taken whenever the count hits a
// multiple of DIV*DIGITS.
module tb_fnd_scan_mux;
  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [15:0] v4;
  logic [19:0] v5;
  logic [3:0]  val4, sel4, val5;
  logic [1:0]  site4;
  logic [2:0]  site5;
  logic [4:0]  sel5;
  logic        tick4, tick5;

  int n_cmp = 0, n_bad = 0;

  // model state
  int          e4, e5;
  logic [31:0] s4, s5;
  bit          t4, t5;

  always #5 clk = ~clk;

  fnd_scan_mux #(.DIGITS(4), .WIDTH(4), .DIV(3)) u4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_values(v4),
    .o_value(val4), .o_site_sel(site4), .o_digit_sel(sel4), .o_frame_tick(tick4));

  fnd_scan_mux #(.DIGITS(5), .WIDTH(4), .DIV(1)) u5 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_values(v5),
    .o_value(val5), .o_site_sel(site5), .o_digit_sel(sel5), .o_frame_tick(tick5));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected active-low enables for one slot.
  function automatic logic [31:0] xsel(int nd, int site, bit on, logic [31:0] snap);
    logic [31:0] r;
    bit          blank;
    r = (32'd1 << nd) - 32'd1;
    blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (site != 0 && (snap >> (site * 4)) == 32'd0) blank = 1'b1;
`endif
    if (on && !blank) r[site] = 1'b0;
    return r;
  endfunction

  task automatic model_edge();
    t4 = 1'b0;
    t5 = 1'b0;
    if (en) begin
      e4++;
      e5++;
      if (e4 % 12 == 0) begin s4 = {16'd0, v4}; t4 = 1'b1; end
      if (e5 % 5 == 0)  begin s5 = {12'd0, v5}; t5 = 1'b1; end
    end
  endtask

  task automatic check_all();
    int st4, st5;
    st4 = (e4 / 3) % 4;
    st5 = e5 % 5;
    chk("site4", {30'd0, site4}, st4);
    chk("val4",  {28'd0, val4},  (s4 >> (st4 * 4)) & 32'hF);
    chk("sel4",  {28'd0, sel4},  xsel(4, st4, en, s4));
    chk("tick4", {31'd0, tick4}, {31'd0, t4 & en});
    chk("site5", {29'd0, site5}, st5);
    chk("val5",  {28'd0, val5},  (s5 >> (st5 * 4)) & 32'hF);
    chk("sel5",  {27'd0, sel5},  xsel(5, st5, en, s5));
    chk("tick5", {31'd0, tick5}, {31'd0, t5 & en});
  endtask

  // Reset pulse placed between clock edges. Outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_sel4",  {28'd0, sel4},  32'hF);
    chk("rst_val4",  {28'd0, val4},  32'd0);
    chk("rst_site4", {30'd0, site4}, 32'd0);
    chk("rst_tick4", {31'd0, tick4}, 32'd0);
    chk("rst_sel5",  {27'd0, sel5},  32'h1F);
    chk("rst_site5", {29'd0, site5}, 32'd0);
    e4 = 0; e5 = 0; s4 = 0; s5 = 0; t4 = 0; t5 = 0;
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_lz();
    logic [31:0] r;
    r = $urandom;
    return r >> (4 * ($urandom % 6));
  endfunction

  initial begin
    logic [31:0] r;
    rst_n = 1'b1; en = 1'b0; v4 = '0; v5 = '0;
    #2 do_reset();
    en = 1'b1;
    v4 = 16'h4321;
    v5 = 20'h54321;
    // Directed first frames from reset.
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); model_edge();
      @(negedge clk); check_all();
      if (c == 2)  chk("slot0_last", {28'd0, sel4}, 32'hE);
      if (c == 3)  chk("slot1_first", {28'd0, sel4}, 32'hD);
      if (c == 11) chk("frame0_zero", {28'd0, val4}, 32'd0);
      if (c == 12) begin
        chk("wrap_tick", {31'd0, tick4}, 32'd1);
        chk("frame1_d0", {28'd0, val4},  32'd1);
      end
      if (c == 13) chk("tick_once", {31'd0, tick4}, 32'd0);
      if (c == 15) begin
        v4 = 16'h8765;
        chk("d1_shown", {28'd0, val4}, 32'd2);
      end
      if (c == 21) chk("tear_free", {28'd0, val4}, 32'd4);
      if (c == 24) chk("new_frame", {28'd0, val4}, 32'd5);
    end
    // Randomized scan with freezes, value churn and resets.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); model_edge();
      @(negedge clk); check_all();
      en = ($urandom % 6) != 0;
      if ($urandom % 5 == 0) begin r = rnd_lz(); v4 = r[15:0]; end
      if ($urandom % 5 == 0) begin r = rnd_lz(); v5 = r[19:0]; end
      if ($urandom % 150 == 0) do_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
